// File: rtl/btn_debounce_mc_pkg.sv
// rtl/btn_debounce_mc_pkg.sv - shared states, defaults and counter sizing for the button conditioner
package btn_debounce_mc_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    PRESS_CHK = 2'b01,
    HELD      = 2'b11,
    REL_CHK   = 2'b10
  } ch_state_t;

  localparam int DEF_N_CH         = 4;
  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_DEBOUNCE_CYC = 100;
  localparam int DEF_LONG_CYC     = 5000;

  // One width serves both counters so they can share comparison constants.
  function automatic int cnt_width(input int debounce_cyc, input int long_cyc);
    int m;
    m = (debounce_cyc > long_cyc) ? debounce_cyc : long_cyc;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_mc_if.sv
// rtl/btn_debounce_mc_if.sv - button inputs and conditioned level/event outputs
interface btn_debounce_mc_if
  import btn_debounce_mc_pkg::*;
#(
  parameter int N_CH = DEF_N_CH
) ();

  logic [N_CH-1:0] btn_in;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] press_pulse;
  logic [N_CH-1:0] release_pulse;
  logic [N_CH-1:0] long_pulse;
  logic            any_event;

  modport master (
    output btn_in,
    input  level, press_pulse, release_pulse, long_pulse, any_event
  );

  modport slave (
    input  btn_in,
    output level, press_pulse, release_pulse, long_pulse, any_event
  );

endinterface

// File: rtl/btn_debounce_mc_ch.sv
// rtl/btn_debounce_mc_ch.sv - one channel: synchroniser, polarity, qualification FSM and hold timer
module btn_debounce_ch
  import btn_debounce_mc_pkg::*;
#(
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int LONG_CYC     = DEF_LONG_CYC,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYC, LONG_CYC);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] DEB_MAX  = CW'(DEBOUNCE_CYC);
  localparam logic [CW-1:0] LONG_MAX = CW'(LONG_CYC);
  localparam bit            LONG_EN  = (LONG_CYC != 0);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_in;

  // Sync flops reset to the inactive electrical level so s_in starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {SYNC_STAGES{ACTIVE_LOW}};
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
  end

  assign s_in = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

  ch_state_t     state, state_nxt;
  logic [CW-1:0] stab_cnt, stab_nxt;
  logic [CW-1:0] hold_cnt, hold_nxt, hold_step;
  logic          long_hit;
  logic          level_nxt, press_nxt, release_nxt, long_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      stab_cnt      <= '0;
      hold_cnt      <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      state         <= state_nxt;
      stab_cnt      <= stab_nxt;
      hold_cnt      <= hold_nxt;
      level         <= level_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
      long_pulse    <= long_nxt;
    end
  end

  always_comb begin
    hold_step   = (hold_cnt != LONG_MAX) ? hold_cnt + ONE : hold_cnt;
    long_hit    = LONG_EN && (hold_cnt != LONG_MAX) && (hold_step == LONG_MAX);
    state_nxt   = state;
    stab_nxt    = stab_cnt;
    hold_nxt    = hold_cnt;
    level_nxt   = level;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    long_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (s_in) begin
          state_nxt = PRESS_CHK;
          stab_nxt  = ONE;
        end
      end
      PRESS_CHK: begin
        if (!s_in) begin
          state_nxt = IDLE;
          stab_nxt  = '0;
        end else if (stab_cnt == DEB_MAX) begin
          state_nxt = HELD;
          stab_nxt  = '0;
          hold_nxt  = '0;
          level_nxt = 1'b1;
          press_nxt = 1'b1;
        end else begin
          stab_nxt = stab_cnt + ONE;
        end
      end
      HELD: begin
        hold_nxt = hold_step;
        long_nxt = long_hit;
        if (!s_in) begin
          state_nxt = REL_CHK;
          stab_nxt  = ONE;
        end
      end
      REL_CHK: begin
        // An accepted release wins over a coincident long-press tick.
        if (!s_in && stab_cnt == DEB_MAX) begin
          state_nxt   = IDLE;
          stab_nxt    = '0;
          level_nxt   = 1'b0;
          release_nxt = 1'b1;
        end else begin
          hold_nxt = hold_step;
          long_nxt = long_hit;
          if (s_in) begin
            state_nxt = HELD;
            stab_nxt  = '0;
          end else begin
            stab_nxt = stab_cnt + ONE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/btn_debounce_mc.sv
// rtl/btn_debounce_mc.sv - N-channel button conditioner with a shared registered event flag
module btn_debounce_mc
  import btn_debounce_mc_pkg::*;
#(
  parameter int N_CH         = DEF_N_CH,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int LONG_CYC     = DEF_LONG_CYC,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  btn_debounce_mc_if.slave bus
);

  logic [N_CH-1:0] level_v;
  logic [N_CH-1:0] press_v;
  logic [N_CH-1:0] release_v;
  logic [N_CH-1:0] long_v;
  logic            any_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_debounce_ch #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_ch (
      .clk           (clk),
      .rst_n         (rst_n),
      .btn           (bus.btn_in[i]),
      .level         (level_v[i]),
      .press_pulse   (press_v[i]),
      .release_pulse (release_v[i]),
      .long_pulse    (long_v[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) any_q <= 1'b0;
    else        any_q <= |(press_v | release_v | long_v);
  end

  assign bus.level         = level_v;
  assign bus.press_pulse   = press_v;
  assign bus.release_pulse = release_v;
  assign bus.long_pulse    = long_v;
  assign bus.any_event     = any_q;

endmodule

// File: tb/tb_btn_debounce_mc.sv
// tb/tb_btn_debounce_mc.sv - vectors, corner sequences and random stimulus against a run-length model
module tb_btn_debounce_mc;
  import btn_debounce_mc_pkg::*;

  localparam int N = 4;
  localparam int S = 2;
  localparam int D = 100;
  localparam int L = 5000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  btn_debounce_mc_if #(.N_CH(N)) bus_hi ();
  btn_debounce_mc_if #(.N_CH(N)) bus_lo ();

  btn_debounce_mc #(.N_CH(N), .SYNC_STAGES(S), .DEBOUNCE_CYC(D), .LONG_CYC(L), .ACTIVE_LOW(1'b0))
    u_hi (.clk(clk), .rst_n(rst_n), .bus(bus_hi));
  btn_debounce_mc #(.N_CH(N), .SYNC_STAGES(S), .DEBOUNCE_CYC(D), .LONG_CYC(L), .ACTIVE_LOW(1'b1))
    u_lo (.clk(clk), .rst_n(rst_n), .bus(bus_lo));

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference: a level flips on the (D+1)th consecutive opposite sample seen S edges late.
  logic [N-1:0] m_level, m_press, m_release, m_long;
  logic         m_any, m_or_prev;
  logic [N-1:0] m_dly[$];
  int           m_run[N];
  int           m_press_t[N];
  int           m_t;

  int n_press[N], n_release[N], n_long[N], n_press_lo[N];
  int t_press[N], t_long[N];
  int n_any_lo;
  logic [N-1:0] win_press_hi, win_release_hi, win_press_lo;

  typedef struct {
    logic [N-1:0] mask;
    int           width;
    logic [N-1:0] exp_evt;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_level = '0; m_press = '0; m_release = '0; m_long = '0;
    m_any = 1'b0; m_or_prev = 1'b0;
    m_dly.delete();
    for (int k = 0; k < S; k++) m_dly.push_back('0);
    for (int c = 0; c < N; c++) begin
      m_run[c] = 0;
      m_press_t[c] = 0;
    end
    m_t = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] b);
    logic [N-1:0] samp;
    samp = m_dly.pop_front();
    m_dly.push_back(b);
    m_any = m_or_prev;
    m_press = '0; m_release = '0; m_long = '0;
    for (int c = 0; c < N; c++) begin
      if (samp[c] != m_level[c]) m_run[c]++;
      else m_run[c] = 0;
      if (m_run[c] == D + 1) begin
        m_level[c] = samp[c];
        m_run[c] = 0;
        if (samp[c]) begin
          m_press[c] = 1'b1;
          m_press_t[c] = m_t;
        end else begin
          m_release[c] = 1'b1;
        end
      end else if (m_level[c] && L != 0 && (m_t - m_press_t[c]) == L) begin
        m_long[c] = 1'b1;
      end
    end
    m_or_prev = |(m_press | m_release | m_long);
    m_t++;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".level"},   bus_hi.level, '0);
    check({tag, ".press"},   bus_hi.press_pulse, '0);
    check({tag, ".release"}, bus_hi.release_pulse, '0);
    check({tag, ".long"},    bus_hi.long_pulse, '0);
    check({tag, ".any"},     {{(N-1){1'b0}}, bus_hi.any_event}, '0);
    check({tag, ".lo_level"}, bus_lo.level, '0);
    check({tag, ".lo_any"},  {{(N-1){1'b0}}, bus_lo.any_event}, '0);
  endtask

  // Inputs change at the falling edge; the following rising edge is the input edge.
  task automatic step(input logic [N-1:0] b);
    bus_hi.btn_in = b;
    bus_lo.btn_in = ~b;
    @(posedge clk);
    model_edge(b);
    @(negedge clk);
    cyc++;
    check("hi.level",   bus_hi.level, m_level);
    check("hi.press",   bus_hi.press_pulse, m_press);
    check("hi.release", bus_hi.release_pulse, m_release);
    check("hi.long",    bus_hi.long_pulse, m_long);
    check("hi.any",     {{(N-1){1'b0}}, bus_hi.any_event}, {{(N-1){1'b0}}, m_any});
    check("lo.level",   bus_lo.level, m_level);
    check("lo.press",   bus_lo.press_pulse, m_press);
    check("lo.release", bus_lo.release_pulse, m_release);
    check("lo.long",    bus_lo.long_pulse, m_long);
    check("lo.any",     {{(N-1){1'b0}}, bus_lo.any_event}, {{(N-1){1'b0}}, m_any});
    for (int c = 0; c < N; c++) begin
      if (bus_hi.press_pulse[c])   begin n_press[c]++; t_press[c] = cyc; end
      if (bus_hi.release_pulse[c]) n_release[c]++;
      if (bus_hi.long_pulse[c])    begin n_long[c]++; t_long[c] = cyc; end
      if (bus_lo.press_pulse[c])   n_press_lo[c]++;
    end
    if (bus_lo.any_event) n_any_lo++;
    win_press_hi   |= bus_hi.press_pulse;
    win_release_hi |= bus_hi.release_pulse;
    win_press_lo   |= bus_lo.press_pulse;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int e, p, l, r, a;
    logic [N-1:0] rb;
    int rem[N];

    vecs[0] = '{4'b0001, 1,   4'b0000};
    vecs[1] = '{4'b0010, 50,  4'b0000};
    vecs[2] = '{4'b0100, 100, 4'b0000};
    vecs[3] = '{4'b1000, 101, 4'b1000};
    vecs[4] = '{4'b0101, 150, 4'b0101};
    vecs[5] = '{4'b1111, 101, 4'b1111};

    bus_hi.btn_in = '0;
    bus_lo.btn_in = '1;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Clean press and release on ch0
    e = cyc + 1;
    repeat (S + D) step(4'b0001);
    check("t1.level_before", bus_hi.level, 4'b0000);
    step(4'b0001);
    check_int("t1.press_lat", cyc - e, S + D);
    check("t1.press", bus_hi.press_pulse, 4'b0001);
    check("t1.level", bus_hi.level, 4'b0001);
    step(4'b0001);
    check("t1.press_width", bus_hi.press_pulse, 4'b0000);
    check("t1.any", {{(N-1){1'b0}}, bus_hi.any_event}, 4'b0001);
    repeat (300 - S - D - 2) step(4'b0001);
    repeat (S + D) step(4'b0000);
    check("t1.no_rel_yet", bus_hi.release_pulse, 4'b0000);
    step(4'b0000);
    check("t1.release", bus_hi.release_pulse, 4'b0001);
    check("t1.level_low", bus_hi.level, 4'b0000);
    step(4'b0000);
    check("t1.rel_any", {{(N-1){1'b0}}, bus_hi.any_event}, 4'b0001);

    // Bounce on ch1, then steady high
    p = n_press[1];
    for (int k = 0; k < 200; k++) begin
      if (k == 180) e = cyc + 1;
      step(((k / 30) % 2 == 0) ? 4'b0010 : 4'b0000);
    end
    check_int("t2.no_press_bounce", n_press[1] - p, 0);
    for (int k = 0; k < 300 && n_press[1] == p; k++) step(4'b0010);
    check_int("t2.press_lat", t_press[1] - e, S + D);
    repeat (S + D + 5) step(4'b0000);

    // Glitch on held ch2, then long press
    p = n_press[2];
    for (int k = 0; k < S + D + 1; k++) step(4'b0100);
    check_int("t3.pressed", n_press[2] - p, 1);
    r = n_release[2];
    l = n_long[2];
    repeat (1000) step(4'b0100);
    repeat (50) step(4'b0000);
    check("t3.level_glitch", bus_hi.level, 4'b0100);
    for (int k = 0; k < L + 10 && n_long[2] == l; k++) step(4'b0100);
    check_int("t3.long_lat", t_long[2] - t_press[2], L);
    check_int("t3.no_release", n_release[2] - r, 0);
    repeat (20) step(4'b0100);
    check_int("t3.long_once", n_long[2] - l, 1);
    repeat (S + D + 5) step(4'b0000);

    // Active-low device: short low pulse ignored, long one accepted on ch3
    a = n_any_lo;
    repeat (50) step(4'b1000);
    repeat (S + D + 5) step(4'b0000);
    check_int("t4.short_no_evt", n_any_lo - a, 0);
    p = n_press_lo[3];
    repeat (150) step(4'b1000);
    repeat (S + D + 5) step(4'b0000);
    check_int("t4.lo_press", n_press_lo[3] - p, 1);

    // All channels on one edge
    repeat (S + D) step(4'b1111);
    step(4'b1111);
    check("t5.press_hi", bus_hi.press_pulse, 4'b1111);
    check("t5.press_lo", bus_lo.press_pulse, 4'b1111);
    step(4'b1111);
    check("t5.any", {{(N-1){1'b0}}, bus_hi.any_event}, 4'b0001);
    check("t5.press_clear", bus_hi.press_pulse, 4'b0000);
    step(4'b1111);
    check("t5.any_once", {{(N-1){1'b0}}, bus_hi.any_event}, 4'b0000);
    repeat (S + D + 5) step(4'b0000);

    // Table of pulse widths around the qualification boundary
    for (int v = 0; v < 6; v++) begin
      win_press_hi = '0; win_release_hi = '0; win_press_lo = '0;
      repeat (vecs[v].width) step(vecs[v].mask);
      repeat (S + D + 10) step(4'b0000);
      check($sformatf("vec%0d.press_hi", v), win_press_hi, vecs[v].exp_evt);
      check($sformatf("vec%0d.release_hi", v), win_release_hi, vecs[v].exp_evt);
      check($sformatf("vec%0d.press_lo", v), win_press_lo, vecs[v].exp_evt);
    end

    // Reset while ch0 is held with hold count at 2000
    p = n_press[0];
    for (int k = 0; k < S + D + 1; k++) step(4'b0001);
    check_int("t6.pressed", n_press[0] - p, 1);
    repeat (2000) step(4'b0001);
    rst_n = 1'b0;
    #1;
    check_zero("t6.async");
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("t6.in_reset");
    rst_n = 1'b1;
    e = cyc + 1;
    p = n_press[0];
    l = n_long[0];
    for (int k = 0; k < S + D + 1; k++) step(4'b0001);
    check_int("t6.repress", n_press[0] - p, 1);
    check_int("t6.repress_lat", t_press[0] - e, S + D);
    for (int k = 0; k < L + 10 && n_long[0] == l; k++) step(4'b0001);
    check_int("t6.long_lat", t_long[0] - t_press[0], L);
    repeat (S + D + 5) step(4'b0000);

    // Random hold lengths, many near the qualification threshold
    rb = '0;
    for (int c = 0; c < N; c++) rem[c] = 0;
    for (int k = 0; k < 4000; k++) begin
      for (int c = 0; c < N; c++) begin
        if (rem[c] == 0) begin
          rb[c] = ~rb[c];
          rem[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(D - 5, D + 40))
                                               : int'($urandom_range(1, 60));
        end else begin
          rem[c]--;
        end
      end
      step(rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btn_debounce_mc.md
Name: btn_debounce_mc

Overview:
- Multi-channel, parametrised button conditioner for board-level push-buttons and switches feeding control and test logic.
- Per channel: synchronises the raw input, normalises polarity and qualifies press/release with a continuous-stability window.
- Outputs a clean level plus one-cycle press, release and long-press pulses.
- Generalises the single-channel, active-high, press-only debouncer: N channels, configurable polarity, release qualification, edge events, long-press detection.

Parameters:
- N_CH, 4, number of independent channels.
- SYNC_STAGES, 2, synchroniser flops per channel (min 2).
- DEBOUNCE_CYC, 100, consecutive stable cycles required to accept a change (min 1).
- LONG_CYC, 5000, cycles of qualified hold before long_pulse; 0 disables long-press.
- ACTIVE_LOW, 0, 1 means btn_in is active-low (inverted after sync).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset (see below).
- btn_in  in  N_CH  raw, asynchronous button inputs.
- level  out  N_CH  debounced active-high state.
- press_pulse  out  N_CH  one-cycle pulse when a press is accepted.
- release_pulse  out  N_CH  one-cycle pulse when a release is accepted.
- long_pulse  out  N_CH  one-cycle pulse when hold time reaches LONG_CYC.
- any_event  out  1  registered OR of all press, release and long pulses of the previous cycle.

Behaviour:
- Reset rst_n, asynchronous, active-low; clock clk.
- Reset state: all outputs 0, sync flops 0 (inactive after polarity), all FSMs IDLE, all counters 0.
- Sync and polarity:
  - s_in[i] = last sync stage, XOR ACTIVE_LOW.
  - All FSM decisions use s_in only.
- Per-channel FSM (states IDLE, PRESS_CHK, HELD, REL_CHK):
  - IDLE (level=0): s_in=1 -> PRESS_CHK, stab_cnt=1.
  - PRESS_CHK:
    - s_in=0 -> IDLE, stab_cnt=0.
    - s_in=1 and stab_cnt=DEBOUNCE_CYC -> HELD: level<=1, press_pulse<=1 for one cycle, hold_cnt=0.
    - Otherwise stab_cnt+1.
  - HELD (level=1):
    - hold_cnt increments, saturating at LONG_CYC.
    - The cycle hold_cnt reaches LONG_CYC: long_pulse<=1, once per press.
    - s_in=0 -> REL_CHK, stab_cnt=1.
  - REL_CHK (level stays 1):
    - s_in=1 -> HELD; hold_cnt is not cleared.
    - s_in=0 and stab_cnt=DEBOUNCE_CYC -> IDLE: level<=0, release_pulse<=1.
    - Otherwise stab_cnt+1.
    - hold_cnt keeps counting, so long_pulse may fire here; it never fires after release.
- Stability is continuous: any opposite sample restarts qualification. A sample-at-end-only check is not acceptable.
- Latency: clean input edge -> level/pulse change = SYNC_STAGES + DEBOUNCE_CYC cycles. Pulses are registered and coincide with the level change.
- Pulses last exactly one cycle. press and release never assert together on a channel. long_pulse may coincide with press_pulse only if LONG_CYC=0, which disables it, so it never does.
- DEBOUNCE_CYC=1: a single stable sample qualifies the change.
- Channels are fully independent. Simultaneous events on several channels all assert in the same cycle; any_event asserts once, one cycle later.
- Mid-operation reset: immediate return to reset state with no pulse emitted. After deassert, a held button requires full re-qualification and produces a fresh press_pulse.
- Counter widths: $clog2(max(DEBOUNCE_CYC, LONG_CYC)+1), with no wrap-around (saturating).

Decomposition:
- Shared package/include holds:
  - FSM state encodings: IDLE=2'b00, PRESS_CHK=2'b01, HELD=2'b11, REL_CHK=2'b10.
  - Counter-width function.
  - Default timing constants.
- One sub-module, btn_debounce_ch: sync, polarity, FSM and counters for one channel, instantiated N_CH times via generate.
- Top level adds the any_event register only.

Test Plan:
1. Clean press on ch0 (DEBOUNCE_CYC=100, SYNC_STAGES=2), held 300 cycles then released clean -> level[0] rises 102 cycles after the input edge with a press_pulse of width 1; release_pulse 102 cycles after the release edge; any_event follows each by one cycle.
2. Bounce: ch1 toggles every 30 cycles for 200 cycles, then steady high -> no pulse during bounce; press_pulse exactly 102 cycles after the last rising toggle.
3. Glitch during REL_CHK: held ch2 drops low 50 cycles, then high -> level stays 1, no release_pulse, hold_cnt continues. With LONG_CYC=5000, long_pulse fires at 5000 cycles after the press is accepted.
4. ACTIVE_LOW=1 with btn_in idle high, ch3 driven low 150 cycles -> press_pulse; a 50-cycle low pulse gives no events.
5. All 4 channels pressed on the same edge -> press_pulse=4'b1111 in a single cycle; any_event high for one cycle.
6. rst_n asserted while ch0 is in HELD at hold_cnt=2000 -> outputs 0 immediately; after release of reset with button still held, press_pulse again at 102 cycles and no long_pulse before 5000 further cycles.
